// File: rtl/csa_digit_serial_adder.sv
// Digit-serial adder: one WIDTH-bit operand set per transaction, summed two bits
// per cycle through a 2-bit carry-skip slice, with valid/ready on both sides.
module csa_digit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [WIDTH-1:0]                  a,
  input  logic [WIDTH-1:0]                  b,
  input  logic                              cin,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [WIDTH-1:0]                  sum,
  output logic                              cout,
  output logic [$clog2(WIDTH/2+1)-1:0]      skip_hits
);

  localparam int NSLICE = WIDTH / 2;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int SKW    = $clog2(NSLICE + 1);

  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NSLICE - 1);
  localparam logic [SKW-1:0]  SKIP_MAX = SKW'(NSLICE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q,     state_d;
  logic [WIDTH-1:0] a_q,         a_d;
  logic [WIDTH-1:0] b_q,         b_d;
  logic             carry_q,     carry_d;
  logic [IDXW-1:0]  idx_q,       idx_d;
  logic [WIDTH-1:0] sum_q,       sum_d;
  logic             cout_q,      cout_d;
  logic [SKW-1:0]   skip_q,      skip_d;
  logic             in_ready_q,  in_ready_d;
  logic             out_valid_q, out_valid_d;

  // Slice operands selected by the current slice index.
  logic [1:0] a_sl, b_sl, p, g, s;
  logic       c1, c2, c_out, skip_hit;

  // NOTE: every signal assigned in an always_comb gets a default on entry,
  // otherwise the paths that skip an assignment infer a latch.
  always_comb begin
    a_sl = 2'b00;
    b_sl = 2'b00;
    for (int i = 0; i < NSLICE; i++) begin
      if (idx_q == IDXW'(i)) begin
        a_sl = a_q[2*i +: 2];
        b_sl = b_q[2*i +: 2];
      end
    end
  end

  // Carry-skip slice: when both bits propagate, the incoming carry bypasses
  // the ripple chain; the result is identical to the rippled carry c2.
  always_comb begin
    p        = a_sl ^ b_sl;
    g        = a_sl & b_sl;
    c1       = g[0] | (p[0] & carry_q);
    c2       = g[1] | (p[1] & c1);
    s        = p ^ {c1, carry_q};
    skip_hit = p[1] & p[0];
    c_out    = skip_hit ? carry_q : c2;
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    skip_d      = skip_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d        = a;
          b_d        = b;
          carry_d    = cin;
          idx_d      = '0;
          skip_d     = '0;
          in_ready_d = 1'b0;
          state_d    = S_RUN;
        end
      end

      S_RUN: begin
        for (int i = 0; i < NSLICE; i++) begin
          if (idx_q == IDXW'(i)) sum_d[2*i +: 2] = s;
        end
        carry_d = c_out;
        if (skip_hit && (skip_q < SKIP_MAX)) skip_d = skip_q + 1'b1;
        if (idx_q == IDX_LAST) begin
          cout_d      = c_out;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      S_DONE: begin
        // Results hold while the consumer stalls; in_valid is ignored here.
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      skip_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      skip_q      <= skip_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign skip_hits = skip_q;

endmodule

// File: tb/tb_csa_digit_serial_adder.sv
// Self-checking bench for csa_digit_serial_adder (WIDTH=8): directed vectors with
// literal expectations plus a transaction-level model checked every cycle.
module tb_csa_digit_serial_adder;

  localparam int WIDTH  = 8;
  localparam int NSLICE = WIDTH / 2;
  localparam int SKW    = $clog2(NSLICE + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a, b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic [SKW-1:0]   skip_hits;

  csa_digit_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .skip_hits (skip_hits)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: result of an accepted op from plain arithmetic.
  typedef struct {
    logic [WIDTH:0] total;
    int             skips;
    int             acc_cyc;
  } exp_t;

  exp_t q[$];

  function automatic int skip_count(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] p;
    int n;
    p = x ^ y;
    n = 0;
    for (int i = 0; i < NSLICE; i++) if (p[2*i] && p[2*i+1]) n++;
    return n;
  endfunction

  int             cyc = 0;
  int             delivered = 0;
  logic [WIDTH-1:0] last_sum;
  logic           last_cout;
  logic [SKW-1:0] last_skip;
  logic [WIDTH-1:0] held_sum = '0;
  logic           held_cout = 1'b0;
  logic [SKW-1:0] held_skip = '0;
  logic           prev_ov = 1'b0;
  logic [WIDTH-1:0] prev_sum;
  logic           prev_cout;
  logic [SKW-1:0] prev_skip;

  // Compare process: inputs and outputs are stable at the falling edge, and a
  // handshake seen here takes effect on the following rising edge.
  always @(negedge clk) begin
    bit   busy, exp_ov;
    exp_t e;
    cyc++;
    if (!rst_n) begin
      q.delete();
      held_sum  = '0;
      held_cout = 1'b0;
      held_skip = '0;
      check("rst_in_ready",  32'(in_ready),  32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_sum",       32'(sum),       32'd0);
      check("rst_cout",      32'(cout),      32'd0);
      check("rst_skip_hits", 32'(skip_hits), 32'd0);
      prev_ov = 1'b0;
    end else begin
      busy   = (q.size() != 0);
      exp_ov = busy && ((cyc - q[0].acc_cyc) >= NSLICE + 1);
      check("in_ready",  32'(in_ready),  32'(!busy));
      check("out_valid", 32'(out_valid), 32'(exp_ov));
      if (!busy) begin
        check("idle_hold_sum",  32'(sum),       32'(held_sum));
        check("idle_hold_cout", 32'(cout),      32'(held_cout));
        check("idle_hold_skip", 32'(skip_hits), 32'(held_skip));
      end
      if (out_valid && prev_ov) begin
        check("stall_sum",  32'(sum),       32'(prev_sum));
        check("stall_cout", 32'(cout),      32'(prev_cout));
        check("stall_skip", 32'(skip_hits), 32'(prev_skip));
      end
      if (out_valid && out_ready && busy) begin
        e = q.pop_front();
        check("model_sum",  32'(sum),       32'(e.total[WIDTH-1:0]));
        check("model_cout", 32'(cout),      32'(e.total[WIDTH]));
        check("model_skip", 32'(skip_hits), 32'(e.skips));
        held_sum  = e.total[WIDTH-1:0];
        held_cout = e.total[WIDTH];
        held_skip = SKW'(e.skips);
        last_sum  = sum;
        last_cout = cout;
        last_skip = skip_hits;
        delivered++;
      end
      if (in_valid && in_ready) begin
        e.total   = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
        e.skips   = skip_count(a, b);
        e.acc_cyc = cyc;
        q.push_back(e);
      end
      prev_ov = out_valid;
    end
    prev_sum  = sum;
    prev_cout = cout;
    prev_skip = skip_hits;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb, input logic tc);
    bit ok;
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    check("accept_wait", 32'(ok), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input int start);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (delivered > start) begin ok = 1'b1; break; end
      tick();
    end
    check("result_wait", 32'(ok), 32'd1);
  endtask

  task automatic run_op(input string name, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                        input logic tc, input logic [WIDTH-1:0] es, input logic ec, input int ek);
    int start;
    start = delivered;
    out_ready = 1'b1;
    send(ta, tb, tc);
    wait_result(start);
    check({name, "_sum"},  32'(last_sum),  32'(es));
    check({name, "_cout"}, 32'(last_cout), 32'(ec));
    check({name, "_skip"}, 32'(last_skip), 32'(ek));
  endtask

  bit rand_done;

  initial begin
    int start;
    bit ok;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;

    // Reset state.
    repeat (3) tick();
    check("t1_in_ready",  32'(in_ready),  32'd1);
    check("t1_out_valid", 32'(out_valid), 32'd0);
    check("t1_sum",       32'(sum),       32'd0);
    check("t1_cout",      32'(cout),      32'd0);
    check("t1_skip",      32'(skip_hits), 32'd0);
    rst_n = 1'b1;
    tick();

    // Carry rippling through every slice; skip path on the upper three.
    run_op("t2", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 3);
    // All slices propagate, then a carry-in-only op with no stale state.
    run_op("t3a", 8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 4);
    run_op("t3b", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 0);

    // Consumer stalls in DONE while a new operand set is offered.
    start = delivered;
    out_ready = 1'b0;
    send(8'h3C, 8'h0F, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (out_valid) begin ok = 1'b1; break; end
      tick();
    end
    check("t4_valid_wait", 32'(ok), 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin a = 8'hFF; b = 8'hFF; cin = 1'b1; in_valid = 1'b1; end
      else in_valid = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    check("t4_in_ready_stall", 32'(in_ready), 32'd0);
    check("t4_delivered_stall", 32'(delivered), 32'(start));
    out_ready = 1'b1;
    wait_result(start);
    check("t4_sum",  32'(last_sum),  32'h4B);
    check("t4_cout", 32'(last_cout), 32'd0);
    check("t4_skip", 32'(last_skip), 32'd2);
    tick();
    check("t4_no_dup", 32'(delivered), 32'(start + 1));
    run_op("t4n", 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 0);

    // Reset while slice 2 is being computed.
    out_ready = 1'b1;
    send(8'h55, 8'h33, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("t5_out_valid", 32'(out_valid), 32'd0);
    check("t5_sum",       32'(sum),       32'd0);
    check("t5_in_ready",  32'(in_ready),  32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    run_op("t5n", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1);

    // Random traffic with gaps on both handshakes.
    start = delivered;
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 500; i++) begin
          send(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
          repeat ($urandom_range(0, 3)) tick();
        end
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
          if (delivered == start + 500) begin ok = 1'b1; break; end
          tick();
        end
        check("t6_all_delivered", 32'(ok), 32'd1);
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          tick();
        end
      end
    join
    check("t6_count", 32'(delivered - start), 32'd500);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
